// File: rtl/string_packer.sv
// string_packer: packs a valid/ready byte stream into a left-aligned WS-byte string, byte 0 in the MSB;
// define STRING_PACKER_TOUPPER_EN to store 'a'..'z' as 'A'..'Z'.
module string_packer #(
    parameter int WS = 8,
    parameter logic [7:0] PAD = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [7:0]                s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [WS*8-1:0]           m_data,
    output logic [$clog2(WS+1)-1:0]   m_len,
    output logic                      m_ovf
);
    localparam int LW = $clog2(WS+1);
    typedef enum logic [1:0] {FILL, DROP, HOLD} state_t;
    state_t state, state_d;
    logic [LW-1:0] cnt;
    logic [WS*8-1:0] data;
    logic ovf, fire, done;
    logic [7:0] wbyte;
    assign s_ready = state != HOLD;
    assign m_valid = state == HOLD;
    assign fire = s_valid && s_ready;
    assign done = m_valid && m_ready;
    assign m_data = data;
    assign m_len = cnt;
    assign m_ovf = ovf;
`ifdef STRING_PACKER_TOUPPER_EN
    assign wbyte = (s_data >= 8'h61 && s_data <= 8'h7a) ? s_data - 8'h20 : s_data;
`else
    assign wbyte = s_data;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= FILL;
        else state <= state_d;
    always_comb begin
        state_d = state;
        case (state)
            FILL:    state_d = fire && s_last ? HOLD : fire && cnt == LW'(WS-1) ? DROP : FILL;
            DROP:    state_d = fire && s_last ? HOLD : DROP;
            HOLD:    state_d = done ? FILL : HOLD;
            default: state_d = FILL;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst || done) begin
            cnt  <= '0;
            data <= {WS{PAD}};
            ovf  <= 1'b0;
        end else if (fire && state == FILL) begin
            data[(WS-int'(cnt))*8-1 -: 8] <= wbyte;
            cnt <= cnt + 1'b1;
        end else if (fire && state == DROP) begin
            ovf <= 1'b1;
        end
endmodule
